mem_dump_tx: RTL

MEM_DUMP_TX -- requirements
Module: mem_dump_tx

---
 rtl/mem_dump_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_dump_tx.sv
// rtl/mem_dump_tx.sv - reads a block of instruction memory and streams it out over an 8N1 UART
//
// Purpose:
//   On a start request, transmits the word count (LSB, MSB) followed by each
//   16-bit memory word (LSB, MSB), matching the format the loader consumes.
//   Bytes are sent back-to-back; the only idle time in the stream is the two
//   cycles per word spent fetching from memory.
//
// Parameters:
//   CLK_FREQ   - CLK frequency in Hz
//   BAUD_RATE  - UART bit rate; BIT_CYCLES = CLK_FREQ / BAUD_RATE clocks per bit
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   asynchronous active-low reset
//   start      in   one-cycle dump request (ignored while a dump is running)
//   word_count in   number of words to dump, sampled with start
//   mem_rd_en  out  one-cycle memory read strobe
//   mem_addr   out  word address, valid while mem_rd_en is high
//   mem_rdata  in   read data, valid the cycle after mem_rd_en
//   tx         out  UART serial line, idle high
//   busy       out  dump in progress
//   done       out  one-cycle completion pulse

module mem_dump_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [15:0] word_count,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [3:0]    BIT_LAST  = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CNT_L,
        SEND_CNT_H,
        FETCH,
        WAIT_DATA,
        SEND_W_L,
        SEND_W_H,
        FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   addr_q,  addr_d;
    logic [15:0]   word_q,  word_d;
    logic [CW-1:0] baud_q,  baud_d;
    logic [3:0]    bit_q,   bit_d;

    logic       sending;
    logic       byte_done;
    logic       last_word;
    logic [7:0] tx_byte;
    logic [9:0] frame;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            count_q <= 16'd0;
            addr_q  <= 16'd0;
            word_q  <= 16'd0;
            baud_q  <= '0;
            bit_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        word_d    = word_q;
        baud_d    = baud_q;
        bit_d     = bit_q;

        sending   = (state_q == SEND_CNT_L) || (state_q == SEND_CNT_H) ||
                    (state_q == SEND_W_L)   || (state_q == SEND_W_H);
        byte_done = sending && (baud_q == BAUD_LAST) && (bit_q == BIT_LAST);
        // Compared in 17 bits so a count of 0xFFFF ends after address 0xFFFE
        // without the address register ever having to hold a wrapped value.
        last_word = ({1'b0, addr_q} + 17'd1) == {1'b0, count_q};

        case (state_q)
            SEND_CNT_L: tx_byte = count_q[7:0];
            SEND_CNT_H: tx_byte = count_q[15:8];
            SEND_W_L:   tx_byte = word_q[7:0];
            SEND_W_H:   tx_byte = word_q[15:8];
            default:    tx_byte = 8'hFF;
        endcase
        // Frame bit 0 is the start bit, 1..8 the data LSB first, 9 the stop bit.
        frame = {1'b1, tx_byte, 1'b0};

        // Bit timer only runs inside a byte; it is back at zero whenever a
        // byte completes, so the next byte starts cleanly on the next cycle.
        if (sending) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                bit_d  = (bit_q == BIT_LAST) ? 4'd0 : bit_q + 4'd1;
            end else begin
                baud_d = baud_q + CW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = word_count;
                    addr_d  = 16'd0;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                    state_d = SEND_CNT_L;
                end
            end
            SEND_CNT_L: begin
                if (byte_done) state_d = SEND_CNT_H;
            end
            SEND_CNT_H: begin
                if (byte_done) state_d = (count_q != 16'd0) ? FETCH : FINISH;
            end
            FETCH: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                word_d  = mem_rdata;
                state_d = SEND_W_L;
            end
            SEND_W_L: begin
                if (byte_done) state_d = SEND_W_H;
            end
            SEND_W_H: begin
                if (byte_done) begin
                    addr_d  = addr_q + 16'd1;
                    state_d = last_word ? FINISH : FETCH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state so reset forces them at once.
    assign tx        = sending ? frame[bit_q] : 1'b1;
    assign mem_rd_en = (state_q == FETCH);
    assign mem_addr  = addr_q;
    assign busy      = (state_q != IDLE) && (state_q != FINISH);
    assign done      = (state_q == FINISH);

endmodule
